// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port unified memory between instruction fetch (IF) and
// the data stage (loads/stores). Each access runs IDLE -> BUSY -> DONE:
// grant and register the request in IDLE, hold the memory interface in BUSY
// until mem_ready or timeout, pulse the owner's ack in DONE.
// Arbitration favours data, but IF is forced through once STARVE_LIMIT
// consecutive data grants have been made while if_req was waiting.
//
// Optional build macro:
//   ARB_PERF_CNT_EN - adds perf_conflict / perf_timeout counters and ports.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack)
//   if_ack/if_rdata     fetch completion pulse and registered instruction
//   d_req/d_we/d_addr/d_wdata   data request, held until d_ack
//   d_ack/d_rdata       data completion pulse and registered load data
//   acc_err             pulses with the ack of a timed-out access
//   stall_if/stall_mem  pipeline stalls (request pending, not yet acked)
//   mem_en/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_ready/mem_rdata memory completion strobe and read data
//   perf_conflict/perf_timeout   (ARB_PERF_CNT_EN only) saturating counters
// ============================================================================
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and register the winner
// BUSY  | mem_en high, request held, waiting for mem_ready or timeout
// DONE  | one-cycle ack to the owner; requests are not sampled here
//
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              acc_err,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [15:0]       perf_timeout
`endif
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_d;      // 1 = data stage owns the access
    logic              err;
    logic [SC_W-1:0]   starve_cnt;
    logic [TO_W-1:0]   timeout_cnt;

    logic              req_any;
    logic              grant_if;
    logic              starved;
    logic              timeout_hit;

    assign req_any     = if_req | d_req;
    assign starved     = (starve_cnt >= SC_W'(STARVE_LIMIT));
    assign grant_if    = if_req & (~d_req | starved);
    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        acc_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_en = 1'b1;
                if (mem_ready || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_ack    = ~owner_d;
                d_ack     = owner_d;
                acc_err   = err;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stalls are combinational so the pipeline releases in the ack cycle.
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    // ------------------------------------------------------------------
    // Request registers, counters and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d     <= 1'b0;
            err         <= 1'b0;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner_d     <= ~grant_if;
                        err         <= 1'b0;
                        timeout_cnt <= '0;
                        if (grant_if) begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end
                        // A data grant only counts against IF if IF was waiting.
                        if (grant_if || !if_req) begin
                            starve_cnt <= '0;
                        end else if (!starved) begin
                            starve_cnt <= starve_cnt + SC_W'(1);
                        end
                    end
                end
                BUSY: begin
                    // mem_ready takes priority over a coincident timeout.
                    if (mem_ready) begin
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                        if (owner_d) begin
                            d_rdata <= '0;
                        end else begin
                            if_rdata <= '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    timeout_cnt <= '0;
                end
                default: begin
                    timeout_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic conflict;

    assign conflict = if_req & d_req & ~if_ack & ~d_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict <= '0;
            perf_timeout  <= '0;
        end else begin
            if (conflict && (perf_conflict != '1)) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (acc_err && (perf_timeout != '1)) begin
                perf_timeout <= perf_timeout + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mem_port_arbiter. A behavioural memory answers mem_en
// after a programmable number of BUSY cycles (or never). Expected grants and
// per-requester completions are queued as stimulus is applied and compared as
// the DUT produces them. With ARB_PERF_CNT_EN defined the perf counters are
// compared against a bench-side conflict count.
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              if_req    = 1'b0;
    logic [ADDR_W-1:0] if_addr   = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req     = 1'b0;
    logic              d_we      = 1'b0;
    logic [ADDR_W-1:0] d_addr    = '0;
    logic [DATA_W-1:0] d_wdata   = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              acc_err;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_conflict;
    logic [15:0]       perf_timeout;
`endif

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .acc_err   (acc_err),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_timeout  (perf_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } gnt_t;

    res_t if_q[$];
    res_t d_q[$];
    gnt_t g_q[$];

    int     n_checks     = 0;
    int     n_fail       = 0;
    int     n_if_ack     = 0;
    int     n_d_ack      = 0;
    int     mem_lat      = 0;
    bit     mem_never    = 1'b0;
    longint exp_conflict = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_grant(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input int len);
        gnt_t g;
        g.addr  = a;
        g.we    = we;
        g.wdata = wd;
        g.len   = len;
        g_q.push_back(g);
    endtask

    task automatic exp_res(input bit is_d, input logic [31:0] rd, input logic e);
        res_t r;
        r.rdata = rd;
        r.err   = e;
        if (is_d) d_q.push_back(r);
        else      if_q.push_back(r);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input string tag, input int want_if, input int want_d,
                             input int max_cyc);
        int gi;
        int gd;
        int cyc;
        gi  = 0;
        gd  = 0;
        cyc = 0;
        while ((gi < want_if || gd < want_d) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            gi += int'(if_ack);
            gd += int'(d_ack);
        end
        check({tag, "_if_acks"}, 64'(gi), 64'(want_if));
        check({tag, "_d_acks"}, 64'(gd), 64'(want_d));
    endtask

    // Behavioural memory: mem_ready in BUSY cycle number mem_lat (0 = first).
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (!mem_never && busy_cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = memf(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0_0000;
                end
                busy_cnt++;
            end else begin
                busy_cnt  = 0;
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_0001;
            end
        end
    end

    // Scoreboard: completions, grants, BUSY stability/length, conflict model.
    initial begin
        gnt_t cur;
        res_t r;
        int   blen;
        logic en_prev;
        cur.addr  = '0;
        cur.we    = 1'b0;
        cur.wdata = '0;
        cur.len   = 0;
        blen      = 0;
        en_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) exp_conflict = 0;
            else if (if_req && d_req && !if_ack && !d_ack) exp_conflict++;

            if (if_ack === 1'b1) begin
                n_if_ack++;
                if (if_q.size() == 0) begin
                    check("if_ack_unexpected", 64'(1), 64'(0));
                end else begin
                    r = if_q.pop_front();
                    check("if_rdata", 64'(if_rdata), 64'(r.rdata));
                    check("if_acc_err", 64'(acc_err), 64'(r.err));
                end
            end
            if (d_ack === 1'b1) begin
                n_d_ack++;
                if (d_q.size() == 0) begin
                    check("d_ack_unexpected", 64'(1), 64'(0));
                end else begin
                    r = d_q.pop_front();
                    check("d_rdata", 64'(d_rdata), 64'(r.rdata));
                    check("d_acc_err", 64'(acc_err), 64'(r.err));
                end
            end

            if (mem_en === 1'b1 && !en_prev) begin
                if (g_q.size() == 0) begin
                    check("grant_unexpected", 64'(1), 64'(0));
                end else begin
                    cur = g_q.pop_front();
                    check("grant_addr", 64'(mem_addr), 64'(cur.addr));
                    check("grant_we", 64'(mem_we), 64'(cur.we));
                    if (cur.we) check("grant_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
                blen = 1;
            end else if (mem_en === 1'b1) begin
                blen++;
                check("busy_addr", 64'(mem_addr), 64'(cur.addr));
                check("busy_we", 64'(mem_we), 64'(cur.we));
                if (cur.we) check("busy_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
            if (mem_en !== 1'b1 && en_prev) begin
                check("busy_len", 64'(blen), 64'(cur.len));
            end
            en_prev = (mem_en === 1'b1);
        end
    end

    initial begin
        int n;
        int base;
        bit seen;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_if_ack", 64'(if_ack), 64'(0));
        check("rst_d_ack", 64'(d_ack), 64'(0));
        check("rst_acc_err", 64'(acc_err), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_if_rdata", 64'(if_rdata), 64'(0));
        check("rst_d_rdata", 64'(d_rdata), 64'(0));
        check("rst_stall_if", 64'(stall_if), 64'(0));
        check("rst_stall_mem", 64'(stall_mem), 64'(0));
        step();
        reset = 1'b0;

        // ---------------- 1: fetch only, minimum latency ----------------
        mem_lat = 0;
        exp_grant(32'h40, 1'b0, 32'h0, 1);
        exp_res(1'b0, memf(32'h40), 1'b0);
        step();
        if_addr = 32'h40;
        if_req  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (if_ack === 1'b1) seen = 1'b1;
            else check("t1_stall_if", 64'(stall_if), 64'(1));
        end
        check("t1_ack_cycle", 64'(n), 64'(3));
        check("t1_stall_if_at_ack", 64'(stall_if), 64'(0));
        step();
        if_req = 1'b0;

        // ---------------- 2: store with slow memory ----------------
        mem_lat = 2;
        base    = n_if_ack;
        exp_grant(32'h100, 1'b1, 32'hDEAD_BEEF, 3);
        exp_res(1'b1, memf(32'h100), 1'b0);
        step();
        d_addr  = 32'h100;
        d_we    = 1'b1;
        d_wdata = 32'hDEAD_BEEF;
        d_req   = 1'b1;
        @(negedge clk);
        check("t2_stall_mem", 64'(stall_mem), 64'(1));
        wait_acks("t2", 0, 1, 40);
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        check("t2_no_if_ack", 64'(n_if_ack), 64'(base));

        // ---------------- 3: continuous conflict, D,D,D,D,I,D ----------------
        mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            exp_grant(32'h300, 1'b0, 32'h0, 1);
            exp_res(1'b1, memf(32'h300), 1'b0);
        end
        exp_grant(32'h200, 1'b0, 32'h0, 1);
        exp_res(1'b0, memf(32'h200), 1'b0);
        exp_grant(32'h300, 1'b0, 32'h0, 1);
        exp_res(1'b1, memf(32'h300), 1'b0);
        step();
        if_addr = 32'h200;
        d_addr  = 32'h300;
        if_req  = 1'b1;
        d_req   = 1'b1;
        wait_acks("t3", 1, 5, 100);
        step();
        if_req = 1'b0;
        d_req  = 1'b0;

        // ---------------- 5: reset in BUSY clears starvation ----------------
        mem_lat = 1;
        for (int i = 0; i < 3; i++) exp_grant(32'h300, 1'b0, 32'h0, 2);
        for (int i = 0; i < 2; i++) exp_res(1'b1, memf(32'h300), 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_grant(32'h300, 1'b0, 32'h0, 2);
            exp_res(1'b1, memf(32'h300), 1'b0);
        end
        exp_grant(32'h200, 1'b0, 32'h0, 2);
        exp_res(1'b0, memf(32'h200), 1'b0);
        step();
        if_req = 1'b1;
        d_req  = 1'b1;
        wait_acks("t5_pre", 0, 2, 50);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_en === 1'b1) seen = 1'b1;
        end
        check("t5_third_grant", 64'(seen), 64'(1));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_mem_en_after_rst", 64'(mem_en), 64'(0));
        check("t5_if_ack_after_rst", 64'(if_ack), 64'(0));
        check("t5_d_ack_after_rst", 64'(d_ack), 64'(0));
        wait_acks("t5_post", 1, 4, 100);
        step();
        if_req = 1'b0;
        d_req  = 1'b0;

        // ---------------- 4: timeout ----------------
        mem_never = 1'b1;
        exp_grant(32'h500, 1'b0, 32'h0, TIMEOUT);
        exp_res(1'b1, 32'h0, 1'b1);
        step();
        d_addr = 32'h500;
        d_we   = 1'b0;
        d_req  = 1'b1;
        wait_acks("t4", 0, 1, 60);
        step();
        d_req     = 1'b0;
        mem_never = 1'b0;
        @(negedge clk);
        check("t4_acc_err_clears", 64'(acc_err), 64'(0));
        check("t4_d_rdata_held", 64'(d_rdata), 64'(0));

`ifdef ARB_PERF_CNT_EN
        // ---------------- 6: performance counters ----------------
        repeat (2) step();
        @(negedge clk);
        check("perf_conflict", 64'(perf_conflict), 64'(exp_conflict[31:0]));
        check("perf_timeout", 64'(perf_timeout), 64'(1));
`endif

        repeat (2) step();
        @(negedge clk);
        check("grant_q_drained", 64'(g_q.size()), 64'(0));
        check("if_q_drained", 64'(if_q.size()), 64'(0));
        check("d_q_drained", 64'(d_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
